// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: BCD MM:SS count with run, pause and adjust
// modes, driven by level clocks from the divider and sampled in the sys_clk domain.
module stopwatch_ctrl (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       onehz_clk,
  input  logic       twohz_clk,
  input  logic       blink_clk,
  input  logic       pause_pulse,
  input  logic       adj_sw,
  input  logic       sel_sw,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       blank_min,
  output logic       blank_sec,
  output logic       paused,
  output logic       adjusting
);

  // state  | meaning
  // RUN    | count advances on each 1 Hz rising edge
  // PAUSED | count holds, all ticks ignored
  // ADJ    | selected field advances on each 2 Hz rising edge, no carry
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJ    = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       paused_q, paused_d;
  logic       onehz_q, twohz_q;
  logic [2:0] min_tens_q, min_tens_d, sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d, sec_ones_q, sec_ones_d;
  logic       blank_min_q, blank_min_d, blank_sec_q, blank_sec_d;
  logic       one_rise, two_rise;
  logic [7:0] sec_inc, min_inc;

  // Returns {carry, tens, ones} for a modulo-60 BCD increment.
  function automatic logic [7:0] bcd_inc(input logic [2:0] tens, input logic [3:0] ones);
    if (ones != 4'd9)      bcd_inc = {1'b0, tens, ones + 4'd1};
    else if (tens != 3'd5) bcd_inc = {1'b0, tens + 3'd1, 4'd0};
    else                   bcd_inc = {1'b1, 3'd0, 4'd0};
  endfunction

  assign one_rise = onehz_clk & ~onehz_q;
  assign two_rise = twohz_clk & ~twohz_q;
  assign sec_inc  = bcd_inc(sec_tens_q, sec_ones_q);
  assign min_inc  = bcd_inc(min_tens_q, min_ones_q);

  always_comb begin
    state_d    = state_q;
    paused_d   = paused_q ^ pause_pulse;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;

    if (adj_sw)        state_d = ST_ADJ;
    else if (paused_d) state_d = ST_PAUSED;
    else               state_d = ST_RUN;

    case (state_q)
      ST_RUN: begin
        if (one_rise) begin
          {sec_tens_d, sec_ones_d} = sec_inc[6:0];
          if (sec_inc[7]) {min_tens_d, min_ones_d} = min_inc[6:0];
        end
      end
      ST_ADJ: begin
        if (two_rise) begin
          if (sel_sw) {sec_tens_d, sec_ones_d} = sec_inc[6:0];
          else        {min_tens_d, min_ones_d} = min_inc[6:0];
        end
      end
      default: ;
    endcase

    blank_min_d = (state_q == ST_ADJ) & ~sel_sw & blink_clk;
    blank_sec_d = (state_q == ST_ADJ) &  sel_sw & blink_clk;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      paused_q    <= 1'b0;
      // Track the live levels so a high input at release is not a tick.
      onehz_q     <= onehz_clk;
      twohz_q     <= twohz_clk;
      min_tens_q  <= 3'd0;
      min_ones_q  <= 4'd0;
      sec_tens_q  <= 3'd0;
      sec_ones_q  <= 4'd0;
      blank_min_q <= 1'b0;
      blank_sec_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      paused_q    <= paused_d;
      onehz_q     <= onehz_clk;
      twohz_q     <= twohz_clk;
      min_tens_q  <= min_tens_d;
      min_ones_q  <= min_ones_d;
      sec_tens_q  <= sec_tens_d;
      sec_ones_q  <= sec_ones_d;
      blank_min_q <= blank_min_d;
      blank_sec_q <= blank_sec_d;
    end
  end

  assign min_tens  = min_tens_q;
  assign min_ones  = min_ones_q;
  assign sec_tens  = sec_tens_q;
  assign sec_ones  = sec_ones_q;
  assign blank_min = blank_min_q;
  assign blank_sec = blank_sec_q;
  assign paused    = paused_q;
  assign adjusting = (state_q == ST_ADJ);

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the stopwatch datapath: consumes the level outputs of the `clocks` divider (`onehz_clk`, `twohz_clk`, `blink_clk`) in the `sys_clk` domain and maintains a BCD MM:SS count. It supports run, pause and adjust modes, with per-field blanking for the display driver. It sits between the `clocks` divider, the debounced button/switch logic and the seven-segment display mux.

## Interface
Parameters: none.

Ports:
- `sys_clk`  in  1  system clock; the only clock. `onehz_clk`, `twohz_clk` and `blink_clk` are derived synchronously from it.
- `rst`  in  1  synchronous, active-high reset.
- `onehz_clk`  in  1  1 Hz level from `clocks`; each rising edge is one count tick.
- `twohz_clk`  in  1  2 Hz level from `clocks`; each rising edge is one adjust tick.
- `blink_clk`  in  1  blink level from `clocks`; high means the selected field is blanked.
- `pause_pulse`  in  1  debounced single-cycle pulse; toggles the pause flag.
- `adj_sw`  in  1  adjust-mode switch level.
- `sel_sw`  in  1  adjust field select: 0 = minutes, 1 = seconds.
- `min_tens`  out  3  minutes tens digit, 0–5.
- `min_ones`  out  4  minutes ones digit, 0–9.
- `sec_tens`  out  3  seconds tens digit, 0–5.
- `sec_ones`  out  4  seconds ones digit, 0–9.
- `blank_min`  out  1  blank the minutes digits.
- `blank_sec`  out  1  blank the seconds digits.
- `paused`  out  1  pause flag.
- `adjusting`  out  1  high while in state ADJ.

## Operation
- Edge detect: `one_rise = onehz_clk & ~onehz_q`. `two_rise` is formed the same way from `twohz_clk`. `onehz_q` and `twohz_q` are registered copies of the inputs.
- States (2-bit register): RUN, PAUSED, ADJ.
- `pause_pulse` toggles `paused` in every state, including ADJ.
- State transitions:
  - Any state → ADJ when `adj_sw` = 1.
  - ADJ → PAUSED when `adj_sw` = 0 and the next `paused` value = 1.
  - ADJ → RUN when `adj_sw` = 0 and the next `paused` value = 0.
  - RUN → PAUSED when a pause pulse sets the flag.
  - PAUSED → RUN when a pause pulse clears the flag.
- RUN behaviour, on `one_rise`:
  - Seconds increment in BCD: `sec_ones` 9 → 0 with carry into `sec_tens`.
  - `sec_tens` 5 with a carry → 0, carrying into minutes.
  - Minutes use the same BCD rules; 59:59 → 00:00 (wrap, no overflow flag).
- PAUSED: the count holds; all ticks are ignored.
- ADJ behaviour:
  - `one_rise` is ignored.
  - On `two_rise`, the selected field increments in BCD modulo 60 (59 → 00).
  - No carry into the other field; the unselected field holds.
- Blanking (registered outputs):
  - `blank_min` = (state==ADJ) & ~`sel_sw` & `blink_clk`.
  - `blank_sec` = (state==ADJ) & `sel_sw` & `blink_clk`.
  - Both are 0 outside ADJ.
- Digit outputs are driven directly from the count registers. Illegal BCD values are unreachable.

## Timing
- Reset values:
  - Digits 0 (00:00), `blank_min`/`blank_sec` 0, `paused` 0, `adjusting` 0, state RUN.
  - During reset, `onehz_q` and `twohz_q` load the current input levels, so a high input at reset release produces no spurious tick.
- Tick latency: `onehz_clk` rises before edge N → `one_rise` is high in that cycle → digits update after edge N.
- Actions are decided from the state register value before the edge. The state update takes effect at the same edge.
- Simultaneous events:
  - `one_rise` and `pause_pulse` in RUN: the tick is applied; `paused` and state change at the same edge.
  - `adj_sw` rises together with `one_rise` in RUN: the tick is applied and state becomes ADJ.
  - `adj_sw` falls together with `two_rise` in ADJ: the adjust increment is applied.
  - `sel_sw` changing mid-ADJ: the new field is used from the next `two_rise`. The blank outputs follow one cycle later.
- Reset mid-count or mid-adjust: the next cycle shows all reset values regardless of inputs.
- Blank outputs lag `blink_clk`, `sel_sw` and state by one cycle.

## Test plan
- Reset, then 61 `onehz_clk` rising edges with no other input → display reads 01:01; `paused` = 0, `adjusting` = 0.
- Preload 59:58 via adjust, return to RUN, apply 2 ticks → 59:59 then 00:00.
- At 00:05 send `pause_pulse`, apply 3 `one_rise` → still 00:05 and `paused` = 1. Second pulse plus 1 tick → 00:06.
- `adj_sw` = 1, `sel_sw` = 0, 61 `two_rise` from 00:00 → 01:00; seconds unchanged; `one_rise` ignored. `blank_min` follows `blink_clk` with a 1-cycle lag; `blank_sec` = 0.
- `adj_sw` = 1, `sel_sw` = 1, seconds at 59, one `two_rise` → seconds 00 and minutes unchanged. Drop `adj_sw` with `paused` = 1 → state PAUSED, blanks 0.
- Assert `rst` for 1 cycle at 12:34 while in ADJ with `onehz_clk` high → 00:00, RUN, all flags 0, no tick on the cycle after reset.
